// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter fed directly by a TX FIFO: pops one byte whenever allowed and
// serialises it as start / data (LSB first) / optional even parity / stop bits.
module uart_tx_fifo_drain #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = 868,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_enable_i,
  input  logic                 fifo_empty_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  output logic                 fifo_read_o,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_tick_o
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end_s;
  logic                 last_stop_s;
  logic                 pop_s;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

  assign bit_end_s   = (timer_q == TW'(BAUD_DIV - 1));
  assign last_stop_s = (state_q == S_STOP) && bit_end_s && (bitcnt_q == CW'(STOP_BITS - 1));
  // Reset gating keeps the pop quiet while the block is held in reset.
  assign pop_s       = rst_ni & tx_enable_i & ~fifo_empty_i & ((state_q == S_IDLE) | last_stop_s);

  assign fifo_read_o    = pop_s;
  assign tx_o           = tx_q;
  assign tx_busy_o      = busy_q;
  assign tx_done_tick_o = last_stop_s;

  // Next-state, bit timing and shift-register update.
  always_comb begin
    state_d  = state_q;
    timer_d  = bit_end_s ? '0 : timer_q + TW'(1);
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pop_s) begin
          state_d  = S_START;
          shreg_d  = fifo_data_i;
          parity_d = even_parity(fifo_data_i);
          bitcnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == CW'(DATA_BITS - 1)) begin
            bitcnt_d = '0;
            state_d  = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d  = S_STOP;
          bitcnt_d = '0;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (last_stop_s) begin
          if (pop_s) begin
            state_d  = S_START;
            shreg_d  = fifo_data_i;
            parity_d = even_parity(fifo_data_i);
            bitcnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (bit_end_s) begin
          bitcnt_d = bitcnt_q + CW'(1);
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // tx is registered, so it is decoded from the state being entered.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

endmodule
